mux_key: RTL and testbench

MUX_KEY -- requirements
Module: mux_key

---
 rtl/mux_key_pkg.sv | 14 +
 rtl/mux_key_core.sv | 48 ++++
 rtl/mux_key.sv | 47 ++++
 tb/tb_mux_key.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/mux_key_pkg.sv
// Shared sizing helpers for the key/data lookup table so callers and the
// lookup logic agree on how wide the packed lut bus is.
package mux_key_pkg;

  // One table entry: key field stacked on top of its data field.
  function automatic int pair_len(input int key_len, input int data_len);
    return key_len + data_len;
  endfunction

  function automatic int lut_width(input int nr_key, input int key_len, input int data_len);
    return nr_key * pair_len(key_len, data_len);
  endfunction

endpackage

// File: rtl/mux_key_core.sv
// Combinational key lookup: every pair whose key equals `key` contributes its
// data to a bitwise OR; with no match the fallback value is driven instead.
module mux_key_core
  import mux_key_pkg::*;
#(
  parameter int NR_KEY      = 2,
  parameter int KEY_LEN     = 1,
  parameter int DATA_LEN    = 1,
  parameter int HAS_DEFAULT = 0
) (
  input  logic [KEY_LEN-1:0]                                key,
  input  logic [DATA_LEN-1:0]                               default_out,
  input  logic [lut_width(NR_KEY, KEY_LEN, DATA_LEN)-1:0]   lut,
  output logic [DATA_LEN-1:0]                               out,
  output logic                                              hit
);

  localparam int PAIR_LEN = pair_len(KEY_LEN, DATA_LEN);

  logic [NR_KEY-1:0]                 match;
  logic [DATA_LEN-1:0][NR_KEY-1:0]   data_col;
  logic [DATA_LEN-1:0]               or_data;
  logic [DATA_LEN-1:0]               fallback;

  for (genvar i = 0; i < NR_KEY; i++) begin : g_pair
    logic [KEY_LEN-1:0]  pair_key;
    logic [DATA_LEN-1:0] pair_data;

    assign pair_key  = lut[i*PAIR_LEN + DATA_LEN +: KEY_LEN];
    assign pair_data = lut[i*PAIR_LEN +: DATA_LEN];
    // An unknown comparison result must never count as a match.
    assign match[i]  = ((key == pair_key) === 1'b1);

    for (genvar b = 0; b < DATA_LEN; b++) begin : g_bit
      assign data_col[b][i] = match[i] & pair_data[b];
    end
  end

  // Column-wise OR keeps the reduction flat instead of a serial chain.
  for (genvar b = 0; b < DATA_LEN; b++) begin : g_or
    assign or_data[b] = |data_col[b];
  end

  assign fallback = (HAS_DEFAULT != 0) ? default_out : '0;
  assign hit      = |match;
  assign out      = hit ? or_data : fallback;

endmodule

// File: rtl/mux_key.sv
// Key lookup with a registered copy of the result; the combinational outputs
// are passed straight through and are untouched by reset.
module mux_key
  import mux_key_pkg::*;
#(
  parameter int NR_KEY      = 2,
  parameter int KEY_LEN     = 1,
  parameter int DATA_LEN    = 1,
  parameter int HAS_DEFAULT = 0
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic [KEY_LEN-1:0]                                key,
  input  logic [DATA_LEN-1:0]                               default_out,
  input  logic [lut_width(NR_KEY, KEY_LEN, DATA_LEN)-1:0]   lut,
  input  logic                                              en,
  output logic [DATA_LEN-1:0]                               out,
  output logic                                              hit,
  output logic [DATA_LEN-1:0]                               out_q,
  output logic                                              hit_q
);

  mux_key_core #(
    .NR_KEY      (NR_KEY),
    .KEY_LEN     (KEY_LEN),
    .DATA_LEN    (DATA_LEN),
    .HAS_DEFAULT (HAS_DEFAULT)
  ) u_core (
    .key         (key),
    .default_out (default_out),
    .lut         (lut),
    .out         (out),
    .hit         (hit)
  );

  // rst is active-low and wins over en for as long as it is held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q <= '0;
      hit_q <= 1'b0;
    end else if (en) begin
      out_q <= out;
      hit_q <= hit;
    end
  end

endmodule

// File: tb/tb_mux_key.sv
// Directed checks of mux_key across several table shapes, including the
// registered stage and asynchronous reset behaviour.
module tb_mux_key;

  int checks   = 0;
  int failures = 0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b0;

  always #5 clk = ~clk;

  // Byte select table: NR_KEY=4, KEY_LEN=2, DATA_LEN=8
  logic [1:0]  key_b;
  logic [7:0]  dflt_b = 8'h00;
  logic [39:0] lut_b  = {2'b00, 8'hDD, 2'b01, 8'hCC, 2'b10, 8'hBB, 2'b11, 8'hAA};
  logic [7:0]  out_b, out_q_b;
  logic        hit_b, hit_q_b;

  // No-match tables: NR_KEY=3, KEY_LEN=2, DATA_LEN=16, with and without default
  logic [1:0]  key_n;
  logic [15:0] dflt_n = 16'h1234;
  logic [53:0] lut_n  = {2'b00, 16'h1111, 2'b01, 16'h2222, 2'b10, 16'h3333};
  logic [15:0] out_n0, out_q_n0, out_n1, out_q_n1;
  logic        hit_n0, hit_q_n0, hit_n1, hit_q_n1;

  // Duplicate keys: NR_KEY=2, KEY_LEN=3, DATA_LEN=32
  logic [2:0]  key_d;
  logic [31:0] dflt_d = 32'h0;
  logic [69:0] lut_d  = {3'b101, 32'h0000_00F0, 3'b101, 32'h0000_000F};
  logic [31:0] out_d, out_q_d;
  logic        hit_d, hit_q_d;

  // Sign-extension table: NR_KEY=5, KEY_LEN=3, DATA_LEN=32
  logic [2:0]   key_s;
  logic [7:0]   sb;
  logic [31:0]  dflt_s = 32'h0;
  logic [174:0] lut_s;
  logic [31:0]  out_s, out_q_s;
  logic         hit_s, hit_q_s;

  assign lut_s = {3'b000, {{24{sb[7]}}, sb},
                  3'b100, {24'b0, sb},
                  3'b001, {sb, 24'b0},
                  3'b010, 32'h0000_0000,
                  3'b011, 32'hFFFF_FFFF};

  // Single comparator with default: NR_KEY=1, KEY_LEN=4, DATA_LEN=4
  logic [3:0] key_o;
  logic [3:0] dflt_o = 4'hC;
  logic [7:0] lut_o  = {4'hA, 4'h5};
  logic [3:0] out_o, out_q_o;
  logic       hit_o, hit_q_o;

  mux_key #(.NR_KEY(4), .KEY_LEN(2), .DATA_LEN(8), .HAS_DEFAULT(0)) u_byte (
    .clk(clk), .rst(rst), .key(key_b), .default_out(dflt_b), .lut(lut_b), .en(en),
    .out(out_b), .hit(hit_b), .out_q(out_q_b), .hit_q(hit_q_b));

  mux_key #(.NR_KEY(3), .KEY_LEN(2), .DATA_LEN(16), .HAS_DEFAULT(0)) u_nm0 (
    .clk(clk), .rst(rst), .key(key_n), .default_out(dflt_n), .lut(lut_n), .en(en),
    .out(out_n0), .hit(hit_n0), .out_q(out_q_n0), .hit_q(hit_q_n0));

  mux_key #(.NR_KEY(3), .KEY_LEN(2), .DATA_LEN(16), .HAS_DEFAULT(1)) u_nm1 (
    .clk(clk), .rst(rst), .key(key_n), .default_out(dflt_n), .lut(lut_n), .en(en),
    .out(out_n1), .hit(hit_n1), .out_q(out_q_n1), .hit_q(hit_q_n1));

  mux_key #(.NR_KEY(2), .KEY_LEN(3), .DATA_LEN(32), .HAS_DEFAULT(0)) u_dup (
    .clk(clk), .rst(rst), .key(key_d), .default_out(dflt_d), .lut(lut_d), .en(en),
    .out(out_d), .hit(hit_d), .out_q(out_q_d), .hit_q(hit_q_d));

  mux_key #(.NR_KEY(5), .KEY_LEN(3), .DATA_LEN(32), .HAS_DEFAULT(0)) u_sx (
    .clk(clk), .rst(rst), .key(key_s), .default_out(dflt_s), .lut(lut_s), .en(en),
    .out(out_s), .hit(hit_s), .out_q(out_q_s), .hit_q(hit_q_s));

  mux_key #(.NR_KEY(1), .KEY_LEN(4), .DATA_LEN(4), .HAS_DEFAULT(1)) u_one (
    .clk(clk), .rst(rst), .key(key_o), .default_out(dflt_o), .lut(lut_o), .en(en),
    .out(out_o), .hit(hit_o), .out_q(out_q_o), .hit_q(hit_q_o));

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] kb, input logic [1:0] kn,
                               input logic [2:0] kd, input logic [2:0] ks,
                               input logic [3:0] ko);
    key_b = kb;
    key_n = kn;
    key_d = kd;
    key_s = ks;
    key_o = ko;
    #1;
  endtask

  initial begin
    sb = 8'h80;
    // Reset asserted from time 0; combinational path must still work.
    applyStimulus(2'b10, 2'b11, 3'b101, 3'b000, 4'hA);
    checkOutput("rst_out_q", {24'b0, out_q_b}, 32'h0);
    checkOutput("rst_hit_q", {31'b0, hit_q_b}, 32'h0);
    checkOutput("byte_key10_out", {24'b0, out_b}, 32'h0000_00BB);
    checkOutput("byte_key10_hit", {31'b0, hit_b}, 32'h1);
    checkOutput("nomatch_nodef_out", {16'b0, out_n0}, 32'h0000_0000);
    checkOutput("nomatch_nodef_hit", {31'b0, hit_n0}, 32'h0);
    checkOutput("nomatch_def_out", {16'b0, out_n1}, 32'h0000_1234);
    checkOutput("nomatch_def_hit", {31'b0, hit_n1}, 32'h0);
    checkOutput("dup_out", out_d, 32'h0000_00FF);
    checkOutput("dup_hit", {31'b0, hit_d}, 32'h1);
    checkOutput("sx_neg_out", out_s, 32'hFFFF_FF80);
    checkOutput("one_match_out", {28'b0, out_o}, 32'h5);
    checkOutput("one_match_hit", {31'b0, hit_o}, 32'h1);

    applyStimulus(2'b11, 2'b01, 3'b000, 3'b100, 4'h3);
    checkOutput("byte_key11_out", {24'b0, out_b}, 32'h0000_00AA);
    checkOutput("nm0_key01_out", {16'b0, out_n0}, 32'h0000_2222);
    checkOutput("nm1_key01_out", {16'b0, out_n1}, 32'h0000_2222);
    checkOutput("nm1_key01_hit", {31'b0, hit_n1}, 32'h1);
    checkOutput("dup_miss_out", out_d, 32'h0);
    checkOutput("dup_miss_hit", {31'b0, hit_d}, 32'h0);
    checkOutput("sx_zext_out", out_s, 32'h0000_0080);
    checkOutput("one_miss_out", {28'b0, out_o}, 32'hC);
    checkOutput("one_miss_hit", {31'b0, hit_o}, 32'h0);

    sb = 8'h7F;
    applyStimulus(2'b00, 2'b00, 3'b101, 3'b000, 4'hA);
    checkOutput("sx_pos_out", out_s, 32'h0000_007F);
    checkOutput("byte_key00_out", {24'b0, out_b}, 32'h0000_00DD);
    checkOutput("nm1_key00_out", {16'b0, out_n1}, 32'h0000_1111);
    lut_o = {4'hA, 4'h9};
    #1;
    checkOutput("one_lut_change_out", {28'b0, out_o}, 32'h9);

    // Reset held across an edge with en=1 must keep the registers clear.
    en = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst_over_en_out_q", {24'b0, out_q_b}, 32'h0);

    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("first_load_out_q", {24'b0, out_q_b}, 32'h0000_00DD);
    checkOutput("first_load_hit_q", {31'b0, hit_q_b}, 32'h1);

    applyStimulus(2'b01, 2'b11, 3'b101, 3'b000, 4'hA);
    checkOutput("reg_comb_now", {24'b0, out_b}, 32'h0000_00CC);
    checkOutput("reg_not_yet", {24'b0, out_q_b}, 32'h0000_00DD);
    @(posedge clk); #1;
    checkOutput("reg_after_edge", {24'b0, out_q_b}, 32'h0000_00CC);
    checkOutput("nm1_hit_q_miss", {31'b0, hit_q_n1}, 32'h0);

    en = 1'b0;
    applyStimulus(2'b10, 2'b11, 3'b101, 3'b000, 4'hA);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("hold_edge%0d", i), {24'b0, out_q_b}, 32'h0000_00CC);
    end

    en = 1'b1;
    @(posedge clk); #1;
    checkOutput("load_bb_out_q", {24'b0, out_q_b}, 32'h0000_00BB);

    // Asynchronous clear between edges.
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_clr_out_q", {24'b0, out_q_b}, 32'h0);
    checkOutput("async_clr_hit_q", {31'b0, hit_q_b}, 32'h0);
    checkOutput("async_clr_out_kept", {24'b0, out_b}, 32'h0000_00BB);
    checkOutput("async_clr_hit_kept", {31'b0, hit_b}, 32'h1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("reload_out_q", {24'b0, out_q_b}, 32'h0000_00BB);
    checkOutput("reload_hit_q", {31'b0, hit_q_b}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
